// File: rtl/cmd_pkg.sv
// Shared definitions for the command block and its involuntary-transmit
// arbiter: unit indices, unit count, index width, arbiter state encoding and
// a small wrap-around index helper.
package cmd_pkg;

    localparam int NUNITS     = 7;
    localparam int UNITS_BITS = 4;

    // Units that may request unsolicited transmission on the response path.
    localparam int UNIT_ENDSTOP_X = 0;
    localparam int UNIT_ENDSTOP_Y = 1;
    localparam int UNIT_ENDSTOP_Z = 2;
    localparam int UNIT_GPIO_IN   = 3;
    localparam int UNIT_ADC       = 4;
    localparam int UNIT_TRSYNC    = 5;
    localparam int UNIT_STEPPER   = 6;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_GRANT = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } arb_state_t;

    // Next index modulo n; n need not be a power of two.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority encoder.
// Finds the first set bit of req at or after ptr, searching upward and
// wrapping from NUNITS-1 back to 0.
// Ports:
//   req   in  NUNITS      request vector
//   ptr   in  UNITS_BITS  search start index (expected < NUNITS)
//   pick  out UNITS_BITS  chosen index (0 when nothing is requested)
//   valid out 1           at least one request bit is set
module rr_pick #(
    parameter int NUNITS     = cmd_pkg::NUNITS,
    parameter int UNITS_BITS = cmd_pkg::UNITS_BITS
) (
    input  logic [NUNITS-1:0]     req,
    input  logic [UNITS_BITS-1:0] ptr,
    output logic [UNITS_BITS-1:0] pick,
    output logic                  valid
);

    // Walk the rotated order from farthest to nearest so the last hit,
    // i.e. the one closest to ptr, is what remains assigned.
    always_comb begin
        int idx;
        pick  = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = NUNITS - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUNITS;
            if (|(req & (NUNITS'(1) << idx))) begin
                pick  = UNITS_BITS'(idx);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/invol_arbiter.sv
// Round-robin arbiter granting the command response path to units that
// want to send unsolicited messages. One session at a time, only while the
// command path is idle; a session ends on the owner's done pulse or on a
// timeout, followed by a short holdoff so host traffic can take the path.
//
// Handshake: a unit holds invol_req high as a level. A grant is a one-cycle
// invol_grant pulse; from then on the unit owns the path until it pulses its
// unit_done bit. sel_valid/sel_unit tell the command FSM who owns the path.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   invol_req    per-unit level requests
//   unit_done    per-unit done pulses (only the owner's bit is observed)
//   path_idle    command FSM idle and no host message pending
//   invol_grant  one-hot one-cycle grant pulse
//   sel_unit     owning unit index, valid while sel_valid
//   sel_valid    session active
//   timeout_err  one-cycle pulse when a session is aborted
//   err_unit     unit of the most recent timeout (sticky)
//   arb_state    current FSM state, for observation
module invol_arbiter #(
    parameter int NUNITS     = cmd_pkg::NUNITS,
    parameter int UNITS_BITS = cmd_pkg::UNITS_BITS,
    parameter int TIMEOUT    = 4096,
    parameter int HOLDOFF    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUNITS-1:0]     invol_req,
    input  logic [NUNITS-1:0]     unit_done,
    input  logic                  path_idle,
    output logic [NUNITS-1:0]     invol_grant,
    output logic [UNITS_BITS-1:0] sel_unit,
    output logic                  sel_valid,
    output logic                  timeout_err,
    output logic [UNITS_BITS-1:0] err_unit,
    output cmd_pkg::arb_state_t   arb_state
);

    import cmd_pkg::*;

    localparam int TCNT_W    = $clog2(TIMEOUT);
    localparam int HCNT_W    = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    // The HOLD state itself accounts for one cycle, so load one less.
    localparam int HOLD_LOAD = (HOLDOFF > 0) ? HOLDOFF - 1 : 0;

    arb_state_t              state_q, state_d;
    logic [UNITS_BITS-1:0]   rr_ptr, rr_ptr_d;
    logic [UNITS_BITS-1:0]   sel_unit_d;
    logic                    sel_valid_d;
    logic [NUNITS-1:0]       grant_d;
    logic                    timeout_err_d;
    logic [UNITS_BITS-1:0]   err_unit_d;
    logic [TCNT_W-1:0]       tcnt, tcnt_d;
    logic [HCNT_W-1:0]       hcnt, hcnt_d;

    logic [UNITS_BITS-1:0]   pick;
    logic                    pick_valid;
    logic [NUNITS-1:0]       owner_mask;
    logic                    owner_done;

    rr_pick #(
        .NUNITS     (NUNITS),
        .UNITS_BITS (UNITS_BITS)
    ) u_pick (
        .req   (invol_req),
        .ptr   (rr_ptr),
        .pick  (pick),
        .valid (pick_valid)
    );

    // Mask rather than bit-select so a foreign done can never match.
    assign owner_mask = NUNITS'(1) << sel_unit;
    assign owner_done = |(unit_done & owner_mask);
    assign arb_state  = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ARB;
            rr_ptr      <= '0;
            sel_unit    <= '0;
            sel_valid   <= 1'b0;
            invol_grant <= '0;
            timeout_err <= 1'b0;
            err_unit    <= '0;
            tcnt        <= '0;
            hcnt        <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr      <= rr_ptr_d;
            sel_unit    <= sel_unit_d;
            sel_valid   <= sel_valid_d;
            invol_grant <= grant_d;
            timeout_err <= timeout_err_d;
            err_unit    <= err_unit_d;
            tcnt        <= tcnt_d;
            hcnt        <= hcnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr;
        sel_unit_d    = sel_unit;
        sel_valid_d   = sel_valid;
        grant_d       = '0;
        timeout_err_d = 1'b0;
        err_unit_d    = err_unit;
        tcnt_d        = tcnt;
        hcnt_d        = hcnt;

        case (state_q)
            ST_ARB: begin
                if (path_idle && pick_valid) begin
                    sel_unit_d  = pick;
                    sel_valid_d = 1'b1;
                    state_d     = ST_GRANT;
                end
            end

            ST_GRANT: begin
                // Registered, so the pulse is visible during the first
                // WAIT cycle, one cycle after sel_valid rose.
                grant_d  = owner_mask;
                tcnt_d   = '0;
                rr_ptr_d = UNITS_BITS'(wrap_inc(int'(sel_unit), NUNITS));
                state_d  = ST_WAIT;
            end

            ST_WAIT: begin
                // Done is checked first so it wins a tie with the timeout.
                if (owner_done) begin
                    sel_valid_d = 1'b0;
                    hcnt_d      = HCNT_W'(HOLD_LOAD);
                    state_d     = (HOLDOFF == 0) ? ST_ARB : ST_HOLD;
                end else if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    err_unit_d    = sel_unit;
                    sel_valid_d   = 1'b0;
                    hcnt_d        = HCNT_W'(HOLD_LOAD);
                    state_d       = (HOLDOFF == 0) ? ST_ARB : ST_HOLD;
                end else begin
                    tcnt_d = tcnt + TCNT_W'(1);
                end
            end

            ST_HOLD: begin
                if (hcnt == '0) begin
                    state_d = ST_ARB;
                end else begin
                    hcnt_d = hcnt - HCNT_W'(1);
                end
            end

            default: begin
                state_d = ST_ARB;
            end
        endcase
    end

endmodule

// File: doc/invol_arbiter.md
# invol_arbiter

Round-robin arbiter that shares the command block's response path (dispatch-wait/param-encode/send stages) between units requesting involuntary (unsolicited) transmission, e.g. endstop trigger reports or periodic GPIO-in polls. It sits between the unit `invol_req`/`invol_grant` lines and the command state machine. It issues one grant at a time, only when the command path is idle. It holds ownership until the granted unit signals `cmd_done`, and recovers from a unit that never finishes.

## Interface
Parameters:
- `NUNITS`, 7: number of requesting units.
- `UNITS_BITS`, 4: width of the unit index.
- `TIMEOUT`, 4096: maximum cycles a grant may stay outstanding before it is aborted.
- `HOLDOFF`, 2: idle cycles enforced after each session, so pending host messages can win the path.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `invol_req`  in  NUNITS: level requests, one per unit.
- `unit_done`  in  NUNITS: `cmd_done` pulses from the units.
- `path_idle`  in  1: command FSM in MST_IDLE and `msg_ready` low.
- `invol_grant`  out  NUNITS: one-hot, one-cycle grant pulse.
- `sel_unit`  out  UNITS_BITS: index of the owning unit, valid while `sel_valid`.
- `sel_valid`  out  1: a session is active; the command FSM steers param capture from `sel_unit`.
- `timeout_err`  out  1: one-cycle pulse when a session is aborted.
- `err_unit`  out  UNITS_BITS: unit of the last timeout, sticky until the next timeout.

## Operation
- States: ARB, GRANT, WAIT, HOLD.
- **ARB**
  - If `path_idle` and any `invol_req` bit is set, pick the first requester at or after `rr_ptr`, searching upward and wrapping at NUNITS-1 to 0.
  - Register the pick into `sel_unit`, set `sel_valid`, and go to GRANT.
  - If `path_idle` is low, stay in ARB and issue no grant.
- **GRANT**
  - `invol_grant[sel_unit]` is high for exactly this cycle.
  - Clear the timeout counter, set `rr_ptr` to `sel_unit+1` (wrapping), and go to WAIT.
- **WAIT**
  - Increment the timeout counter each cycle.
  - On `unit_done[sel_unit]`, clear `sel_valid`, load the holdoff counter, and go to HOLD.
  - If the counter reaches TIMEOUT-1 without done: pulse `timeout_err`, load `err_unit`, clear `sel_valid`, and go to HOLD.
  - If done and timeout occur in the same cycle, done wins and no error is raised.
  - `unit_done` from non-owning units is ignored.
- **HOLD**: count down HOLDOFF cycles, then return to ARB. If HOLDOFF is 0, go straight to ARB on the next cycle.
- A request that drops before ARB samples it is never granted. A request that drops after selection is still granted; the unit must tolerate this.
- `rr_ptr` advances only on a grant, so a unit is granted at most once per NUNITS grants while others are pending.
- Counter width is `$clog2(TIMEOUT)`. All index arithmetic is modulo NUNITS, and NUNITS need not be a power of two.

## Timing
- Reset values: state=ARB, `rr_ptr`=0, `invol_grant`=0, `sel_unit`=0, `sel_valid`=0, `timeout_err`=0, `err_unit`=0, counters=0.
- Reset mid-session drops ownership immediately; there is no grant pulse after reset release.
- Grant latency: request and `path_idle` seen at edge N, `sel_valid` high after N, `invol_grant` high for the cycle after N+1.
- `sel_valid` rises one cycle before the grant pulse and falls on the edge that samples done or timeout.
- Minimum spacing between two grants is 3+HOLDOFF cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `cmd_pkg`: UNIT_* indices, NUNITS, UNITS_BITS, and the state encoding. The command block uses the same package.
- Natural sub-module `rr_pick`: a combinational rotate-priority encoder. Inputs are the request vector and the pointer; outputs are the index and a valid bit. It is reused by a future output-FIFO arbiter.

## Test plan
- **Single request:** reset, `path_idle`=1, `invol_req`=0b0001000 → `sel_unit`=3 and `sel_valid` high one cycle later, `invol_grant`=0b0001000 for 1 cycle. `unit_done[3]` 5 cycles later → `sel_valid` low, next grant no earlier than HOLDOFF+1 cycles.
- **Round-robin:** all 7 requests held, each `unit_done` returned after 2 cycles → grants in order 0,1,2,3,4,5,6,0. Wrap occurs with no unit repeated inside a round.
- **Path busy:** `invol_req[2]`=1 with `path_idle`=0 for 20 cycles → no grant. `path_idle` rises → grant to unit 2 within 2 cycles.
- **Timeout:** TIMEOUT=16, grant unit 4, never done → `timeout_err` pulse exactly 16 cycles after GRANT, `err_unit`=4, arbiter serves unit 5 next.
- **Done/timeout tie and foreign done:** `unit_done[1]` during unit 4's session is ignored. Done on the timeout cycle → no `timeout_err`.
- **Async reset mid-WAIT:** all outputs 0 immediately, before the next clock edge. After release, first grant goes to the lowest pending index at or after 0.
